lock_input_conditioner: RTL and testbench

- Front-end stage feeding lockSystem in the canal-lock design.
- Synchronizes, debounces and edge-detects the four control switches: gondola arriving, gondola departing, outer port, inner port.
- Does the same for the two active-low water-level buttons: raise and lower.
- Emits clean levels and single-cycle event pulses, with hold-to-repeat on the water buttons and a raise/lower interlock, so lockSystem never sees metastable, bouncing or contradictory commands.

---
 rtl/lock_input_conditioner.sv | 134 +++++++++++++
 tb/tb_lock_input_conditioner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lock_input_conditioner.sv
// Input conditioner for the canal-lock controller: sync, debounce and edge-detect switches and
// water keys, with key auto-repeat (enabled by LOCK_IN_REPEAT_EN) and a raise/lower interlock.
module lock_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_raw,
  input  logic [1:0] key_n_raw,
  output logic [3:0] sw_level,
  output logic [3:0] sw_rise,
  output logic [3:0] sw_fall,
  output logic [1:0] key_held,
  output logic [1:0] key_press
);

  localparam int NB = 6;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

`ifdef LOCK_IN_REPEAT_EN
  typedef enum logic [1:0] {K_IDLE, K_DELAY, K_REPEAT, K_LOCKOUT} key_state_e;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rcnt_q [2];
`else
  typedef enum logic {K_IDLE, K_LOCKOUT} key_state_e;
`endif

  logic [3:0]    sw_s1_q, sw_s2_q;
  logic [1:0]    key_s1_q, key_s2_q;
  logic [NB-1:0] sync_w;
  logic [NB-1:0] lvl_q, lvl_d;
  logic [DW-1:0] cnt_q [NB];
  logic [DW-1:0] cnt_d [NB];
  logic [3:0]    rise_q, fall_q;
  logic [1:0]    press_q;
  logic [1:0]    held_nx;
  key_state_e    state_q [2];

  // Bits [3:0] are switches, [5:4] are keys converted to active-high after the chain.
  assign sync_w = {~key_s2_q, sw_s2_q};

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      lvl_d[i] = lvl_q[i];
      if (sync_w[i] != lvl_q[i]) begin
        if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = ~lvl_q[i];
        else                                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      key_s1_q <= '1;
      key_s2_q <= '1;
      lvl_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
      key_s1_q <= key_n_raw;
      key_s2_q <= key_s1_q;
      lvl_q    <= lvl_d;
      rise_q   <= lvl_d[3:0] & ~lvl_q[3:0];
      fall_q   <= ~lvl_d[3:0] & lvl_q[3:0];
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // The key FSMs look at the level being registered this edge, so the first press pulse
  // lines up with the cycle key_held first reads 1.
  assign held_nx = lvl_d[5:4];

  always_ff @(posedge clk) begin
    if (reset) begin
      press_q <= '0;
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= K_IDLE;
`ifdef LOCK_IN_REPEAT_EN
        rcnt_q[k]  <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (&held_nx) begin
          state_q[k] <= K_LOCKOUT;
        end else if (!held_nx[k]) begin
          state_q[k] <= K_IDLE;
        end else begin
          case (state_q[k])
            K_IDLE: begin
              press_q[k] <= 1'b1;
`ifdef LOCK_IN_REPEAT_EN
              state_q[k] <= K_DELAY;
              rcnt_q[k]  <= RW'(REPEAT_DELAY);
`else
              // Without repeat, LOCKOUT doubles as "wait for release".
              state_q[k] <= K_LOCKOUT;
`endif
            end
`ifdef LOCK_IN_REPEAT_EN
            K_DELAY, K_REPEAT: begin
              if (rcnt_q[k] == RW'(1)) begin
                press_q[k] <= 1'b1;
                rcnt_q[k]  <= RW'(REPEAT_PERIOD);
                state_q[k] <= K_REPEAT;
              end else begin
                rcnt_q[k]  <= rcnt_q[k] - 1'b1;
              end
            end
`endif
            default: state_q[k] <= K_LOCKOUT;
          endcase
        end
      end
    end
  end

  assign sw_level  = lvl_q[3:0];
  assign sw_rise   = rise_q;
  assign sw_fall   = fall_q;
  assign key_held  = lvl_q[5:4];
  assign key_press = press_q;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Bench for lock_input_conditioner: directed scenarios then random stimulus, every cycle
// compared against a window/age based reference model. Honours LOCK_IN_REPEAT_EN.
module tb_lock_input_conditioner;

  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_raw;
  logic [1:0] key_n_raw;
  logic [3:0] sw_level, sw_rise, sw_fall;
  logic [1:0] key_held, key_press;

  always #5 clk = ~clk;

  lock_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .key_n_raw(key_n_raw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .key_held (key_held),
    .key_press(key_press)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: inputs viewed active-high, bits [3:0] switches, [5:4] keys.
  logic [5:0] m_s1, m_s2, m_lvl;
  logic [5:0] win_q[$];
  logic [1:0] m_locked, m_active;
  int         m_start [2];
  int         edge_n = 0;
  logic [3:0] e_rise, e_fall;
  logic [1:0] e_press;

  always @(posedge clk) begin : model
    logic       r;
    logic [5:0] raw6, used, nl;
    logic [1:0] h, hp;
    logic       all_diff;
    int         age;
    r    = reset;
    raw6 = {~key_n_raw, sw_raw};
    #1;
    edge_n++;
    e_rise  = '0;
    e_fall  = '0;
    e_press = '0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      win_q.delete();
      m_locked = '0; m_active = '0;
    end else begin
      used = m_s2;
      m_s2 = m_s1;
      m_s1 = raw6;
      win_q.push_back(used);
      if (win_q.size() > D) void'(win_q.pop_front());
      // Level flips once the last D synced samples all disagree with it.
      nl = m_lvl;
      if (win_q.size() == D) begin
        for (int b = 0; b < 6; b++) begin
          all_diff = 1'b1;
          foreach (win_q[j]) if (win_q[j][b] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) nl[b] = ~m_lvl[b];
        end
      end
      e_rise = nl[3:0] & ~m_lvl[3:0];
      e_fall = ~nl[3:0] & m_lvl[3:0];
      h  = nl[5:4];
      hp = m_lvl[5:4];
      for (int k = 0; k < 2; k++) if (!h[k]) begin m_locked[k] = 1'b0; m_active[k] = 1'b0; end
      if (h == 2'b11) begin
        m_locked = 2'b11;
        m_active = 2'b00;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (h[k]) begin
            if (!hp[k] && !m_locked[k]) begin
              m_active[k] = 1'b1;
              m_start[k]  = edge_n;
              e_press[k]  = 1'b1;
            end else if (m_active[k]) begin
              age = edge_n - m_start[k];
`ifdef LOCK_IN_REPEAT_EN
              if (age == RD || (age > RD && (age - RD) % RP == 0)) e_press[k] = 1'b1;
`else
              if (age < 0) e_press[k] = 1'b1;
`endif
            end
          end
        end
      end
      m_lvl = nl;
    end
    check("sw_level",  {4'b0, sw_level},  {4'b0, m_lvl[3:0]});
    check("sw_rise",   {4'b0, sw_rise},   {4'b0, e_rise});
    check("sw_fall",   {4'b0, sw_fall},   {4'b0, e_fall});
    check("key_held",  {6'b0, key_held},  {6'b0, m_lvl[5:4]});
    check("key_press", {6'b0, key_press}, {6'b0, e_press});
  end

  task automatic drive(input logic rst, input logic [3:0] sw, input logic [1:0] kn, input int cycles);
    reset     = rst;
    sw_raw    = sw;
    key_n_raw = kn;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    sw_raw    = 4'b0000;
    key_n_raw = 2'b11;
    repeat (3) @(negedge clk);
    // Switch debounce, rise then fall.
    drive(1'b0, 4'b0001, 2'b11, 15);
    drive(1'b0, 4'b0000, 2'b11, 12);
    // Short glitch on depart.
    drive(1'b0, 4'b0010, 2'b11, 3);
    drive(1'b0, 4'b0000, 2'b11, 12);
    // Hold-to-repeat on raise, then release.
    drive(1'b0, 4'b0000, 2'b10, 20);
    drive(1'b0, 4'b0000, 2'b11, 12);
    // Interlock: both together, release lower, release and re-press raise.
    drive(1'b0, 4'b0000, 2'b00, 15);
    drive(1'b0, 4'b0000, 2'b10, 15);
    drive(1'b0, 4'b0000, 2'b11, 10);
    drive(1'b0, 4'b0000, 2'b10, 15);
    drive(1'b0, 4'b0000, 2'b11, 12);
    // Reset while repeating.
    drive(1'b0, 4'b0101, 2'b10, 20);
    drive(1'b1, 4'b0101, 2'b10, 1);
    drive(1'b0, 4'b0101, 2'b10, 25);
    drive(1'b0, 4'b0000, 2'b11, 12);
    // Long hold on lower; all switches at once.
    drive(1'b0, 4'b1111, 2'b01, 30);
    drive(1'b0, 4'b0000, 2'b11, 12);
    // Random phase with occasional resets and bouncy short holds.
    for (int i = 0; i < 400; i++) begin
      logic       rst;
      logic [3:0] sw;
      logic [1:0] kn;
      int         cyc;
      rst = ($urandom_range(0, 39) == 0);
      sw  = 4'($urandom_range(0, 15));
      kn  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) kn = 2'b11;
      cyc = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30) : $urandom_range(1, 6);
      if (rst) cyc = 1;
      drive(rst, sw, kn, cyc);
    end
    drive(1'b0, 4'b0000, 2'b11, 12);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
